// File: rtl/serial_frame_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared state encoding, line levels and sizing helper for the
//               serial frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DATA      = 3'd1;
    localparam logic [2:0] ST_PARITY    = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit-counter width; a single-bit counter is kept even for DATA_W=1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx_if
// Description : Serial line input and parallel word/flag outputs of the frame
//               receiver, grouped for the receiver (master) and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              din;
    logic [DATA_W-1:0] dout;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        input  din,
        output dout,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output din,
        input  dout,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_rx_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter
// Description : Clear/enable data-bit counter with a terminal-count flag that
//               marks the last data bit of a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
    import serial_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int              CNT_W  = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_rx
// Description : One-bit-per-clock serial frame receiver: start, DATA_W bits
//               LSB first, optional parity, stop; strobes word and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_frame_rx_if.master    bus
);
    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam logic PARITY_EXP = (PARITY_ODD != 0);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;

    bit_counter #(
        .DATA_W (DATA_W)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        par_d        = par_q;
        dout_d       = dout_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.din == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_clr = 1'b1;
                    par_d   = 1'b0;
                end
            end
            ST_DATA: begin
                // Shift in from the top so the first bit lands in the LSB.
                shift_d           = shift_q >> 1;
                shift_d[DATA_W-1] = bus.din;
                par_d             = par_q ^ bus.din;
                cnt_en            = ~cnt_tc;
                if (cnt_tc) begin
                    state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                par_d   = par_q ^ bus.din;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bus.din == STOP_BIT) begin
                    dout_d       = shift_q;
                    data_valid_d = 1'b1;
                    parity_err_d = HAS_PARITY & (par_q ^ PARITY_EXP);
                    state_d      = ST_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line must return high before a new start counts.
                if (bus.din == LINE_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            par_q        <= 1'b0;
            dout_q       <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            dout_q       <= dout_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Scoreboard bench for serial_frame_rx: an 8-bit even-parity
//               instance and a 5-bit no-parity instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_rx;

    typedef struct {
        logic [15:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   fq0[$];
    int   fq1[$];
    logic [15:0] last0 = '0;
    logic [15:0] last1 = '0;

    serial_frame_rx_if #(.DATA_W(8)) if0 ();
    serial_frame_rx_if #(.DATA_W(5)) if1 ();

    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    serial_frame_rx #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: parity error when the count of ones in data+parity has the wrong oddness.
    function automatic logic ref_perr(input int pe, input int odd, input logic [15:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (pe != 0) && ((ones % 2) != odd);
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? if0.busy : if1.busy;
    endfunction

    task automatic drive_bit(input int w, input logic b);
        @(negedge clk);
        if (w == 0) if0.din = b;
        else        if1.din = b;
    endtask

    task automatic idle(input int w, input int n);
        repeat (n) begin
            drive_bit(w, 1'b1);
            chk("busy_idle", 32'(busy_of(w)), 32'd0);
        end
    endtask

    task automatic send_frame(input int w, input logic [15:0] data, input logic pbit,
                              input logic stopb, input int hold);
        int          dw, pe, c;
        exp_t        e;
        logic [15:0] m;
        dw = (w == 0) ? 8 : 5;
        pe = (w == 0) ? 1 : 0;
        m  = data & ((16'h1 << dw) - 16'h1);
        drive_bit(w, 1'b0);
        c = cyc;
        if (stopb) begin
            e.data = m;
            e.perr = ref_perr(pe, 0, m, pbit);
            e.cyc  = c + dw + pe + 2;
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end else begin
            if (w == 0) fq0.push_back(c + dw + pe + 2);
            else        fq1.push_back(c + dw + pe + 2);
        end
        for (int i = 0; i < dw; i++) drive_bit(w, m[i]);
        if (pe != 0) drive_bit(w, pbit);
        drive_bit(w, stopb);
        if (!stopb) begin
            repeat (hold) begin
                drive_bit(w, 1'b0);
                chk("busy_wait_idle", 32'(busy_of(w)), 32'd1);
            end
            drive_bit(w, 1'b1);
        end
    endtask

    task automatic mon(input int w, input logic dv, input logic pe, input logic fe,
                       input logic [15:0] d);
        exp_t e;
        int   fc;
        if (dv) begin
            if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid[%0d]: dout %0h with no frame pending (cycle %0d)", w, d, cyc);
            end else begin
                if (w == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("dout", 32'(d), 32'(e.data));
                chk("parity_err", 32'(pe), 32'(e.perr));
                chk("valid_cycle", cyc, e.cyc);
                if (w == 0) last0 = e.data;
                else        last1 = e.data;
            end
        end else begin
            chk("parity_err_without_valid", 32'(pe), 32'd0);
        end
        if (fe) begin
            if ((w == 0 && fq0.size() == 0) || (w == 1 && fq1.size() == 0)) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_frame_err[%0d]: got 1, expected 0 (cycle %0d)", w, cyc);
            end else begin
                if (w == 0) fc = fq0.pop_front();
                else        fc = fq1.pop_front();
                chk("frame_err_cycle", cyc, fc);
                chk("dout_held", 32'(d), (w == 0) ? 32'(last0) : 32'(last1));
                chk("valid_on_frame_err", 32'(dv), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if0.data_valid, if0.parity_err, if0.frame_err, {8'h00, if0.dout});
            mon(1, if1.data_valid, if1.parity_err, if1.frame_err, {11'h000, if1.dout});
        end
    end

    task automatic check_reset_outputs();
        chk("rst_dout0", 32'(if0.dout), 32'd0);
        chk("rst_valid0", 32'(if0.data_valid), 32'd0);
        chk("rst_perr0", 32'(if0.parity_err), 32'd0);
        chk("rst_ferr0", 32'(if0.frame_err), 32'd0);
        chk("rst_busy0", 32'(if0.busy), 32'd0);
        chk("rst_dout1", 32'(if1.dout), 32'd0);
    endtask

    initial begin
        logic [7:0] d8;
        logic       pb;

        if0.din = 1'b1;
        if1.din = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(0, 3);

        // Good frame, parity error, framing error with held-low line
        send_frame(0, 16'hA5, 1'b0, 1'b1, 0);
        idle(0, 2);
        send_frame(0, 16'hA5, 1'b1, 1'b1, 0);
        idle(0, 2);
        send_frame(0, 16'h3C, 1'b0, 1'b0, 5);
        idle(0, 3);

        // Back-to-back frames with no idle gap
        send_frame(0, 16'h12, 1'b0, 1'b1, 0);
        send_frame(0, 16'hFE, 1'b1, 1'b1, 0);
        idle(0, 2);

        // Asynchronous reset after four data bits of 0x55
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, (8'h55 >> i) & 8'h01 ? 1'b1 : 1'b0);
        #7 rst = 1'b1;
        if0.din = 1'b1;
        #1 check_reset_outputs();
        last0 = '0;
        last1 = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(0, 2);
        send_frame(0, 16'h0F, 1'b0, 1'b1, 0);
        idle(0, 2);

        // Randomised frames on the 8-bit parity instance
        for (int n = 0; n < 30; n++) begin
            d8 = 8'($urandom);
            pb = ^d8;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            send_frame(0, {8'h00, d8}, pb, ($urandom_range(0, 5) != 0), int'($urandom_range(0, 5)));
            idle(0, int'($urandom_range(0, 2)));
        end
        idle(0, 2);

        // 5-bit, no-parity instance: directed 0x0D then random frames
        idle(1, 2);
        send_frame(1, 16'h000D, 1'b0, 1'b1, 0);
        idle(1, 2);
        for (int n = 0; n < 15; n++) begin
            send_frame(1, 16'($urandom), 1'b0, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 4)));
            idle(1, int'($urandom_range(0, 2)));
        end

        // Drain: every pending expectation must have been consumed
        repeat (20) @(negedge clk);
        chk("pending_frames0", q0.size(), 0);
        chk("pending_frames1", q1.size(), 0);
        chk("pending_ferr0", fq0.size(), 0);
        chk("pending_ferr1", fq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
